// File: rtl/demux_rr_sched_pkg.sv
// Shared definitions for the 4-way demux round-robin scheduler: channel count,
// select width, FSM state encoding and a one-hot helper.
package demux_rr_sched_pkg;

   localparam int unsigned N_CH  = 4;
   localparam int unsigned SEL_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_GAP  = 2'd2
   } sched_state_e;

   function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
      return N_CH'(1) << idx;
   endfunction

endpackage

// File: rtl/demux_rr_sched_rr_arb4.sv
// Combinational round-robin pick: first set request after the last granted
// channel, wrapping modulo 4.
module rr_arb4
   import demux_rr_sched_pkg::*;
(
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] last,
   output logic             any,
   output logic [SEL_W-1:0] win_idx,
   output logic [N_CH-1:0]  win_onehot
);

   logic             found;
   logic [SEL_W-1:0] idx;

   always_comb begin
      any     = |req;
      win_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int k = 1; k <= int'(N_CH); k++) begin
         idx = last + SEL_W'(k);
         if (!found && req[idx]) begin
            win_idx = idx;
            found   = 1'b1;
         end
      end
      win_onehot = any ? onehot(win_idx) : '0;
   end

endmodule

// File: rtl/demux_rr_sched.sv
// Round-robin scheduler sharing one serial source among four demux channels,
// pacing the source in fixed-length bursts separated by idle gaps.
module demux_rr_sched
   import demux_rr_sched_pkg::*;
#(
   parameter int unsigned BURST_LEN   = 4,
   parameter int unsigned CNT_W       = 4,
   parameter int unsigned GAP_CYC     = 1,
   parameter bit          ACTIVE_HIGH = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_CH-1:0]  req,
   input  logic             src_valid,
   output logic             src_ready,
   output logic [N_CH-1:0]  gnt,
   output logic             dmx_en,
   output logic [SEL_W-1:0] dmx_sel,
   output logic             dmx_hl,
   output logic [CNT_W-1:0] beat_cnt,
   output logic             xfer_done,
   output logic             aborted,
   output logic             busy
);

   localparam int unsigned GAP_W = 3;

   sched_state_e     state_q, state_d;
   logic [SEL_W-1:0] last_q, last_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [N_CH-1:0]  gnt_d;
   logic [SEL_W-1:0] dmx_sel_d;
   logic [CNT_W-1:0] beat_cnt_d;
   logic             src_ready_d, dmx_en_d, xfer_done_d, aborted_d, busy_d;
   logic             launch, go_idle, hs, last_beat;

   logic             arb_any;
   logic [SEL_W-1:0] arb_idx;
   logic [N_CH-1:0]  arb_onehot;

   rr_arb4 u_arb (
      .req        (req),
      .last       (last_q),
      .any        (arb_any),
      .win_idx    (arb_idx),
      .win_onehot (arb_onehot)
   );

   // src_ready is high exactly while in XFER, so it doubles as the XFER qualifier
   assign hs        = src_valid && src_ready;
   assign last_beat = hs && (beat_cnt == CNT_W'(BURST_LEN - 1));

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      gap_cnt_d   = gap_cnt_q;
      gnt_d       = gnt;
      dmx_en_d    = dmx_en;
      dmx_sel_d   = dmx_sel;
      src_ready_d = src_ready;
      beat_cnt_d  = beat_cnt;
      busy_d      = busy;
      xfer_done_d = 1'b0;
      aborted_d   = 1'b0;
      launch      = 1'b0;
      go_idle     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (arb_any) launch = 1'b1;
            else         go_idle = 1'b1;
         end
         ST_XFER: begin
            if (hs) beat_cnt_d = beat_cnt + CNT_W'(1);
            // completion takes precedence over a coincident request drop
            if (last_beat || !req[dmx_sel]) begin
               state_d     = ST_GAP;
               last_d      = dmx_sel;
               gap_cnt_d   = '0;
               gnt_d       = '0;
               dmx_en_d    = 1'b0;
               src_ready_d = 1'b0;
               xfer_done_d = 1'b1;
               aborted_d   = !last_beat;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
               if (arb_any) launch = 1'b1;
               else         go_idle = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: go_idle = 1'b1;
      endcase

      if (launch) begin
         state_d     = ST_XFER;
         gnt_d       = arb_onehot;
         dmx_sel_d   = arb_idx;
         dmx_en_d    = 1'b1;
         src_ready_d = 1'b1;
         beat_cnt_d  = '0;
         busy_d      = 1'b1;
      end
      if (go_idle) begin
         state_d     = ST_IDLE;
         gnt_d       = '0;
         dmx_en_d    = 1'b0;
         src_ready_d = 1'b0;
         beat_cnt_d  = '0;
         busy_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         last_q    <= SEL_W'(N_CH - 1);
         gap_cnt_q <= '0;
         gnt       <= '0;
         dmx_en    <= 1'b0;
         dmx_sel   <= '0;
         src_ready <= 1'b0;
         beat_cnt  <= '0;
         xfer_done <= 1'b0;
         aborted   <= 1'b0;
         busy      <= 1'b0;
         dmx_hl    <= ACTIVE_HIGH;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         gap_cnt_q <= gap_cnt_d;
         gnt       <= gnt_d;
         dmx_en    <= dmx_en_d;
         dmx_sel   <= dmx_sel_d;
         src_ready <= src_ready_d;
         beat_cnt  <= beat_cnt_d;
         xfer_done <= xfer_done_d;
         aborted   <= aborted_d;
         busy      <= busy_d;
         dmx_hl    <= ACTIVE_HIGH;
      end
   end

endmodule

// File: tb/tb_demux_rr_sched.sv
// Self-checking bench for demux_rr_sched: directed scenarios with literal
// expectations plus randomized traffic against a burst-level reference model.
module tb_demux_rr_sched;

   localparam int unsigned BURST_LEN   = 4;
   localparam int unsigned CNT_W       = 4;
   localparam int unsigned GAP_CYC     = 1;
   localparam bit          ACTIVE_HIGH = 1'b1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [3:0]       req;
   logic             src_valid;
   logic             src_ready;
   logic [3:0]       gnt;
   logic             dmx_en;
   logic [1:0]       dmx_sel;
   logic             dmx_hl;
   logic [CNT_W-1:0] beat_cnt;
   logic             xfer_done;
   logic             aborted;
   logic             busy;

   demux_rr_sched #(
      .BURST_LEN   (BURST_LEN),
      .CNT_W       (CNT_W),
      .GAP_CYC     (GAP_CYC),
      .ACTIVE_HIGH (ACTIVE_HIGH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .gnt       (gnt),
      .dmx_en    (dmx_en),
      .dmx_sel   (dmx_sel),
      .dmx_hl    (dmx_hl),
      .beat_cnt  (beat_cnt),
      .xfer_done (xfer_done),
      .aborted   (aborted),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // reference model: mode 0 idle, 1 transferring, 2 gap
   int         m_mode, m_last, m_g, m_cnt, m_gapleft;
   logic [3:0] e_gnt;
   int         e_sel, e_cnt;
   bit         e_en, e_rdy, e_done, e_ab, e_busy;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic int pick(input logic [3:0] r, input int last);
      for (int k = 1; k <= 4; k++)
         if (r[(last + k) % 4]) return (last + k) % 4;
      return 0;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_last = 3; m_g = 0; m_cnt = 0; m_gapleft = 0;
      e_gnt = '0; e_sel = 0; e_cnt = 0;
      e_en = 0; e_rdy = 0; e_done = 0; e_ab = 0; e_busy = 0;
   endtask

   task automatic model_grant(input int w);
      m_mode = 1; m_g = w; m_cnt = 0;
      e_gnt = '0; e_gnt[w] = 1'b1;
      e_sel = w; e_en = 1; e_rdy = 1; e_busy = 1;
   endtask

   task automatic model_idle();
      m_mode = 0; m_cnt = 0;
      e_gnt = '0; e_en = 0; e_rdy = 0; e_busy = 0;
   endtask

   // advance the model by one clock using the inputs seen at that edge
   task automatic model_step(input logic [3:0] r, input bit v);
      bit full;
      e_done = 0; e_ab = 0;
      case (m_mode)
         0: if (r != 0) model_grant(pick(r, m_last)); else model_idle();
         1: begin
            if (v) m_cnt++;
            full = v && (m_cnt == BURST_LEN);
            if (full || !r[m_g]) begin
               m_mode = 2; m_gapleft = GAP_CYC; m_last = m_g;
               e_done = 1; e_ab = !full;
               e_gnt = '0; e_en = 0; e_rdy = 0;
            end
         end
         default: begin
            m_gapleft--;
            if (m_gapleft == 0) begin
               if (r != 0) model_grant(pick(r, m_last)); else model_idle();
            end
         end
      endcase
      e_cnt = m_cnt;
   endtask

   task automatic compare_all();
      chk("gnt",       32'(gnt),       32'(e_gnt));
      chk("dmx_sel",   32'(dmx_sel),   32'(e_sel));
      chk("dmx_en",    32'(dmx_en),    32'(e_en));
      chk("src_ready", 32'(src_ready), 32'(e_rdy));
      chk("beat_cnt",  32'(beat_cnt),  32'(e_cnt));
      chk("xfer_done", 32'(xfer_done), 32'(e_done));
      chk("aborted",   32'(aborted),   32'(e_ab));
      chk("busy",      32'(busy),      32'(e_busy));
      chk("dmx_hl",    32'(dmx_hl),    32'(ACTIVE_HIGH));
   endtask

   task automatic run_cycle(input logic [3:0] r, input bit v);
      req = r; src_valid = v;
      @(posedge clk);
      cyc++;
      model_step(r, v);
      #1;
      compare_all();
   endtask

   // asserts reset away from an edge and checks outputs clear asynchronously
   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      chk("rst_gnt",       32'(gnt),       32'd0);
      chk("rst_dmx_en",    32'(dmx_en),    32'd0);
      chk("rst_src_ready", 32'(src_ready), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_beat_cnt",  32'(beat_cnt),  32'd0);
      chk("rst_dmx_sel",   32'(dmx_sel),   32'd0);
      chk("rst_dmx_hl",    32'(dmx_hl),    32'(ACTIVE_HIGH));
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
   endtask

   int         order_q[$];
   int         exp_order[5] = '{0, 1, 2, 3, 0};
   logic [3:0] prev_gnt;
   logic [3:0] rnd_req;

   initial begin
      req = '0; src_valid = 1'b0; rst_n = 1'b1;
      #3;
      do_reset();

      // idle with no requests
      for (int i = 0; i < 5; i++) run_cycle(4'b0000, 1'b0);
      chk("idle_gnt", 32'(gnt), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      // req 0101: channel 0, then channel 2, then back to 0
      run_cycle(4'b0101, 1'b1);
      chk("dir_gnt_e1", 32'(gnt), 32'b0001);
      chk("dir_rdy_e1", 32'(src_ready), 32'd1);
      for (int i = 2; i <= 5; i++) run_cycle(4'b0101, 1'b1);
      chk("dir_done_e5", 32'(xfer_done), 32'd1);
      chk("dir_ab_e5", 32'(aborted), 32'd0);
      chk("dir_cnt_e5", 32'(beat_cnt), 32'd4);
      run_cycle(4'b0101, 1'b1);
      chk("dir_gnt_e6", 32'(gnt), 32'b0100);
      chk("dir_sel_e6", 32'(dmx_sel), 32'd2);
      for (int i = 7; i <= 11; i++) run_cycle(4'b0101, 1'b1);
      chk("dir_gnt_e11", 32'(gnt), 32'b0001);

      // mid-burst reset, then all channels requesting
      do_reset();
      prev_gnt = '0;
      for (int i = 0; i < 30; i++) begin
         run_cycle(4'b1111, 1'b1);
         if (gnt != 0 && prev_gnt == 0) order_q.push_back(int'(dmx_sel));
         if (xfer_done) chk("fair_burst_cnt", 32'(beat_cnt), 32'd4);
         prev_gnt = gnt;
      end
      chk("fair_grant_count", 32'(order_q.size() >= 5), 32'd1);
      for (int i = 0; i < 5; i++)
         if (i < order_q.size()) chk("fair_order", 32'(order_q[i]), 32'(exp_order[i]));

      // src_valid toggling: beats only on handshake edges 2,4,6,8
      do_reset();
      for (int k = 1; k <= 8; k++) run_cycle(4'b0001, (k % 2) == 0);
      chk("stall_done_e8", 32'(xfer_done), 32'd1);
      chk("stall_cnt_e8", 32'(beat_cnt), 32'd4);
      chk("stall_sel_e8", 32'(dmx_sel), 32'd0);

      // abort of channel 1 after two beats, next grant to channel 3
      do_reset();
      for (int k = 1; k <= 3; k++) run_cycle(4'b1010, 1'b1);
      run_cycle(4'b1000, 1'b0);
      chk("abort_done", 32'(xfer_done), 32'd1);
      chk("abort_flag", 32'(aborted), 32'd1);
      chk("abort_cnt", 32'(beat_cnt), 32'd2);
      run_cycle(4'b1000, 1'b1);
      chk("abort_next_gnt", 32'(gnt), 32'b1000);

      // request drop together with the final beat counts as completion
      for (int k = 6; k <= 8; k++) run_cycle(4'b1000, 1'b1);
      run_cycle(4'b0000, 1'b1);
      chk("coinc_done", 32'(xfer_done), 32'd1);
      chk("coinc_ab", 32'(aborted), 32'd0);
      chk("coinc_cnt", 32'(beat_cnt), 32'd4);
      run_cycle(4'b0000, 1'b0);

      // randomized traffic against the model
      rnd_req = 4'b0000;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 5) == 0) rnd_req = 4'($urandom_range(0, 15));
         run_cycle(rnd_req, $urandom_range(0, 3) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
